fetch_stage: RTL and testbench

- Instruction fetch stage sitting directly upstream of the control/ALU-control decoder.
- Holds the PC and issues single-outstanding requests to instruction memory.
- Buffers returned words in an IF/ID register plus a 1-entry skid buffer.
- Presents opcode/funct3/funct7 fields to decode with valid/ready; branch/jump redirects from EX flush in-flight work.

---
 rtl/fetch_pkg.sv | 36 +++
 rtl/fetch_skid_buf.sv | 41 ++++
 rtl/fetch_stage.sv | 147 ++++++++++++++
 tb/tb_fetch_stage.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its decoder.
// Optional perf counters in fetch_stage are enabled with FETCH_PERF_CNT_EN.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_DROP
    } fetch_state_t;

    localparam int PC_INC_DEFAULT = 4;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int F3_LSB  = 12;
    localparam int F3_MSB  = 14;
    localparam int F7_LSB  = 25;
    localparam int F7_MSB  = 31;

    localparam logic [6:0] OP_RTYPE = 7'b0000000;
    localparam logic [6:0] OP_ITYPE = 7'b0000001;
    localparam logic [6:0] OP_LW    = 7'b0000010;
    localparam logic [6:0] OP_SW    = 7'b0000011;
    localparam logic [6:0] OP_BR    = 7'b0000100;
    localparam logic [6:0] OP_JAL   = 7'b0000101;
    localparam logic [6:0] OP_JALR  = 7'b0000110;

    // Saturating 32-bit accumulate used by the event counters.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, a} + 33'(inc);
        return sum[32] ? '1 : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding register that catches a response when IF/ID is stalled.
module fetch_skid_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            drain,
    input  logic            flush,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    output logic            valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

    // NOTE: payload is reset as well, so nothing downstream ever observes X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pc    <= '0;
            out_instr <= '0;
        end else if (load) begin
            out_pc    <= in_pc;
            out_instr <= in_instr;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem requests, IF/ID register plus skid.
// Define FETCH_PERF_CNT_EN to add the perf_fetched/perf_flushed counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_INC   = PC_INC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    output logic [6:0]      id_opcode,
    output logic [2:0]      id_funct3,
    output logic [6:0]      id_funct7
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_instr;

    logic req_fire, redir, capture, drain, if_open;
    logic if_from_skid, if_from_rsp, skid_load;

    assign imem_req_valid = (state == S_REQ) && !skid_valid;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign redir          = redirect_valid && (state != S_BOOT);
    assign capture        = (state == S_WAIT) && imem_rsp_valid && !redir;
    assign drain          = id_valid && id_ready;
    assign if_open        = !id_valid || drain;
    // The skid entry is older than any new response, so it refills IF/ID first.
    assign if_from_skid   = !redir && if_open && skid_valid;
    assign if_from_rsp    = capture && if_open && !skid_valid;
    assign skid_load      = capture && !if_open;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_BOOT;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            case (state)
                S_BOOT: state <= S_REQ;
                S_REQ: begin
                    if (req_fire) begin
                        req_pc <= pc;
                        state  <= redir ? S_DROP : S_WAIT;
                        pc     <= redir ? redirect_pc : pc + XLEN'(PC_INC);
                    end else if (redir) begin
                        pc <= redirect_pc;
                    end
                end
                S_WAIT: begin
                    if (redir) begin
                        pc    <= redirect_pc;
                        state <= imem_rsp_valid ? S_REQ : S_DROP;
                    end else if (imem_rsp_valid) begin
                        state <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (redir) pc <= redirect_pc;
                    if (imem_rsp_valid) state <= S_REQ;
                end
                default: state <= S_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            id_pc    <= '0;
            id_instr <= '0;
        end else if (redir) begin
            id_valid <= 1'b0;
        end else if (if_from_skid) begin
            id_valid <= 1'b1;
            id_pc    <= skid_pc;
            id_instr <= skid_instr;
        end else if (if_from_rsp) begin
            id_valid <= 1'b1;
            id_pc    <= req_pc;
            id_instr <= imem_rsp_data;
        end else if (drain) begin
            id_valid <= 1'b0;
        end
    end

    fetch_skid_buf #(.XLEN(XLEN)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .drain     (if_from_skid),
        .flush     (redir),
        .in_pc     (req_pc),
        .in_instr  (imem_rsp_data),
        .valid     (skid_valid),
        .out_pc    (skid_pc),
        .out_instr (skid_instr)
    );

    assign id_opcode = id_instr[OPC_MSB:OPC_LSB];
    assign id_funct3 = id_instr[F3_MSB:F3_LSB];
    assign id_funct7 = id_instr[F7_MSB:F7_LSB];

`ifdef FETCH_PERF_CNT_EN
    logic       rsp_discard;
    logic [1:0] flush_inc;

    assign rsp_discard = imem_rsp_valid &&
                         ((state == S_DROP) || ((state == S_WAIT) && redir));
    // An IF/ID entry accepted by decode in the redirect cycle is consumed, not flushed.
    assign flush_inc   = 2'(rsp_discard) + 2'(redir && id_valid && !id_ready) +
                         2'(redir && skid_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            perf_fetched <= sat_add(perf_fetched, 2'(if_from_skid || if_from_rsp));
            perf_flushed <= sat_add(perf_flushed, flush_inc);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for the boot stream plus hand sequences.
// Perf counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [6:0]  id_funct7;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
    logic [31:0] flush_base;
`endif

    int passed = 0;
    int total  = 0;

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .PC_INC(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_opcode      (id_opcode),
        .id_funct3      (id_funct3),
        .id_funct7      (id_funct7)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h4000_5033;
        return {a[23:0], 8'h13};
    endfunction

    // Memory model: handshake sampled 1 ns before the edge, response driven
    // mem_lat cycles later; outstanding responses survive a DUT reset.
    int          mem_lat = 1;
    int          due     = 0;
    logic        hs_next = 1'b0;
    logic [31:0] addr_next = '0;
    logic [31:0] addr_due  = '0;

    initial forever begin
        @(negedge clk);
        #4;
        hs_next   = imem_req_valid && imem_req_ready;
        addr_next = imem_req_addr;
    end

    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (hs_next) begin
                due      = mem_lat;
                addr_due = addr_next;
            end
            if (due > 0) begin
                due--;
                if (due == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(addr_due);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_req(input string name, input logic exp_valid, input logic [31:0] exp_addr);
        check({name, "_req_valid"}, 32'(imem_req_valid), 32'(exp_valid));
        check({name, "_req_addr"}, imem_req_addr, exp_addr);
    endtask

    task automatic check_id(input string name, input logic exp_valid, input logic [31:0] exp_pc);
        check({name, "_id_valid"}, 32'(id_valid), 32'(exp_valid));
        if (exp_valid) begin
            check({name, "_id_pc"}, id_pc, exp_pc);
            check({name, "_id_instr"}, id_instr, mem_word(exp_pc));
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic check_flush(input string name, input logic [31:0] delta);
        check(name, perf_flushed - flush_base, delta);
        flush_base = perf_flushed;
    endtask
`endif

    typedef struct {
        logic        req_valid;
        logic [31:0] req_addr;
        logic        id_valid;
        logic [31:0] id_pc;
    } vec_t;

    vec_t vecs[8];

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;

        // Boot stream with 1-cycle memory: REQ/WAIT alternate, one instr per 2 cycles.
        vecs[0] = '{1'b0, 32'h0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 32'h0, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 32'h4, 1'b0, 32'h0};
        vecs[3] = '{1'b1, 32'h4, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 32'h8, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 32'h8, 1'b1, 32'h4};
        vecs[6] = '{1'b0, 32'hC, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 32'hC, 1'b1, 32'h8};

        repeat (2) @(negedge clk);
        check_req("reset", 1'b0, 32'h0);
        check_id("reset", 1'b0, 32'h0);
        check("reset_id_pc", id_pc, 32'h0);
        check("reset_id_instr", id_instr, 32'h0);
        check("reset_opcode", 32'(id_opcode), 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("reset_perf_fetched", perf_fetched, 32'h0);
        check("reset_perf_flushed", perf_flushed, 32'h0);
`endif

        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check_req($sformatf("boot%0d", i), vecs[i].req_valid, vecs[i].req_addr);
            check_id($sformatf("boot%0d", i), vecs[i].id_valid, vecs[i].id_pc);
            if (i == 3) begin
                check("field_opcode", 32'(id_opcode), 32'h33);
                check("field_funct3", 32'(id_funct3), 32'h5);
                check("field_funct7", 32'(id_funct7), 32'h20);
            end
        end

        // Decode stall: next word parks in the skid and fetching stops.
        id_ready = 1'b0;
        @(negedge clk);
        check_req("stall_wait", 1'b0, 32'h10);
        check_id("stall_wait", 1'b1, 32'h8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_req($sformatf("stall_skid%0d", i), 1'b0, 32'h10);
            check_id($sformatf("stall_skid%0d", i), 1'b1, 32'h8);
        end
        id_ready = 1'b1;
        @(negedge clk);
        check_id("skid_drain", 1'b1, 32'hC);
        check_req("skid_drain", 1'b1, 32'h10);
        @(negedge clk);
        check_id("after_skid", 1'b0, 32'h0);
        @(negedge clk);
        check_id("post_skid_fetch", 1'b1, 32'h10);
        check_req("post_skid_fetch", 1'b1, 32'h14);

        // Redirect while waiting on a slow response; the late word is dropped.
`ifdef FETCH_PERF_CNT_EN
        flush_base = perf_flushed;
`endif
        mem_lat = 3;
        @(negedge clk);
        check_req("slow_wait", 1'b0, 32'h18);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        check_req("drop_state", 1'b0, 32'h100);
        check_id("drop_state", 1'b0, 32'h0);
        @(negedge clk);
        check_req("drop_hold", 1'b0, 32'h100);
        @(negedge clk);
        check_req("drop_done", 1'b1, 32'h100);
        check_id("drop_done", 1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check_flush("flush_late_rsp", 32'd1);
`endif
        mem_lat = 1;
        @(negedge clk);
        @(negedge clk);
        check_id("redir_target", 1'b1, 32'h100);
        check_req("redir_target", 1'b1, 32'h104);

        // Redirect coinciding with a response while IF/ID is stalled.
        id_ready = 1'b0;
        @(negedge clk);
        check_id("rsp_redir_setup", 1'b1, 32'h100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        check_id("rsp_redir", 1'b0, 32'h0);
        check_req("rsp_redir", 1'b1, 32'h200);
`ifdef FETCH_PERF_CNT_EN
        check_flush("flush_rsp_and_ifid", 32'd2);
`endif

        // Redirect on the same edge as a request handshake.
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        @(negedge clk);
        redirect_valid = 1'b0;
        check_req("hs_redir_drop", 1'b0, 32'h300);
        @(negedge clk);
        check_req("hs_redir_req", 1'b1, 32'h300);
        check_id("hs_redir_req", 1'b0, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check_flush("flush_hs_redir", 32'd1);
`endif
        @(negedge clk);
        @(negedge clk);
        check_id("hs_redir_fetch", 1'b1, 32'h300);

        // Redirect with both IF/ID and skid full.
        id_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_req("skid_full", 1'b0, 32'h308);
        check_id("skid_full", 1'b1, 32'h300);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        @(negedge clk);
        redirect_valid = 1'b0;
        check_id("skid_flush", 1'b0, 32'h0);
        check_req("skid_flush", 1'b1, 32'h400);
`ifdef FETCH_PERF_CNT_EN
        check_flush("flush_ifid_and_skid", 32'd2);
`endif
        id_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_id("skid_flush_fetch", 1'b1, 32'h400);
        check_req("skid_flush_fetch", 1'b1, 32'h404);

        // Memory backpressure holds the address; redirect retargets it; PC wraps.
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_req($sformatf("bp_hold%0d", i), 1'b1, 32'h404);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        check_req("bp_retarget", 1'b1, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        @(negedge clk);
        check_req("pc_wrap", 1'b0, 32'h0);
        @(negedge clk);
        check_id("wrap_fetch", 1'b1, 32'hFFFF_FFFC);

        // Asynchronous reset mid-WAIT; the stale response lands after release.
        id_ready = 1'b0;
        mem_lat  = 3;
        @(negedge clk);
        check_req("pre_reset_wait", 1'b0, 32'h4);
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        #1;
        check_req("async_reset", 1'b0, 32'h0);
        check_id("async_reset", 1'b0, 32'h0);
        check("async_reset_id_instr", id_instr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_req("post_boot", 1'b1, 32'h0);
        @(negedge clk);
        check_id("stale_ignored", 1'b0, 32'h0);
        check_req("stale_ignored", 1'b1, 32'h0);
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        mem_lat        = 1;
        @(negedge clk);
        @(negedge clk);
        check_id("refetch_reset_pc", 1'b1, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
